// File: rtl/arm_alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the sequential ARM ALU.
package arm_alu_pkg;

    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_EOR = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_RSB = 5'd3;
    localparam logic [4:0] OP_ADD = 5'd4;
    localparam logic [4:0] OP_ADC = 5'd5;
    localparam logic [4:0] OP_SBC = 5'd6;
    localparam logic [4:0] OP_RSC = 5'd7;
    localparam logic [4:0] OP_TST = 5'd8;
    localparam logic [4:0] OP_TEQ = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd10;
    localparam logic [4:0] OP_CMN = 5'd11;
    localparam logic [4:0] OP_ORR = 5'd12;
    localparam logic [4:0] OP_MOV = 5'd13;
    localparam logic [4:0] OP_BIC = 5'd14;
    localparam logic [4:0] OP_MVN = 5'd15;
    localparam logic [4:0] OP_MUL = 5'd16;
    localparam logic [4:0] OP_MLA = 5'd17;

    typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic is_compare(input logic [4:0] op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    function automatic logic is_logical(input logic [4:0] op);
        return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN};
    endfunction

endpackage

// File: rtl/arm_alu_dp.sv
// Combinational ARM data-processing core: all 16 DP opcodes through one shared adder.
module arm_alu_dp
    import arm_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             v
);
    logic [WIDTH-1:0] x, y;
    logic             ci, arith;
    logic [WIDTH:0]   sum;

    always_comb begin
        x     = a;
        y     = b;
        ci    = 1'b0;
        arith = 1'b1;
        // Subtractions are x + ~y + carry-in, so the carry out is already NOT borrow.
        case ({1'b0, op})
            OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
            OP_ADD, OP_CMN: ci = 1'b0;
            OP_ADC:         ci = cin;
            OP_SBC:         begin y = ~b; ci = cin; end
            OP_RSC:         begin x = b; y = ~a; ci = cin; end
            default:        arith = 1'b0;
        endcase

        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

        case ({1'b0, op})
            OP_AND, OP_TST: result = a & b;
            OP_EOR, OP_TEQ: result = a ^ b;
            OP_ORR:         result = a | b;
            OP_MOV:         result = b;
            OP_BIC:         result = a & ~b;
            OP_MVN:         result = ~b;
            default:        result = sum[WIDTH-1:0];
        endcase

        c = arith ? sum[WIDTH] : cin;
        v = arith && (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

// File: rtl/arm_alu_seq.sv
// Sequential ARM ALU: 1-cycle DP ops, shift-add MUL/MLA, valid/ready I/O and an internal NZCV
// register.
module arm_alu_seq
    import arm_alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_STEPS = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Acc,
    input  logic [4:0]       OP,
    input  logic             S,
    input  logic             Flags_Load,
    input  logic [3:0]       Flags_In,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out,
    output logic             Wr_En,
    output logic             Illegal,
    output logic [3:0]       FLAGS_OUT
);
    localparam int unsigned CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    state_e           state_q;
    logic [WIDTH-1:0] out_q, mul_a_q, mul_b_q, prod_q, prod_next, dp_result;
    logic             out_valid_q, wr_en_q, illegal_q, mul_s_q;
    logic             dp_c, dp_v, accept, is_mul;
    logic [3:0]       flags_q;
    logic [CW-1:0]    cnt_q;

    arm_alu_dp #(.WIDTH(WIDTH)) u_dp (
        .a      (A),
        .b      (B),
        .op     (OP[3:0]),
        .cin    (flags_q[FLAG_C]),
        .result (dp_result),
        .c      (dp_c),
        .v      (dp_v)
    );

    assign In_Ready  = (state_q == StIdle) && (!out_valid_q || Out_Ready);
    assign accept    = In_Valid && In_Ready;
    assign is_mul    = (OP == OP_MUL) || (OP == OP_MLA);
    // Multiplicand pre-shifted and multiplier consumed LSB-first, so bit 0 is always B[cnt].
    assign prod_next = prod_q + (mul_b_q[0] ? mul_a_q : '0);

    assign Out_Valid = out_valid_q;
    assign Out       = out_q;
    assign Wr_En     = wr_en_q;
    assign Illegal   = illegal_q;
    assign FLAGS_OUT = flags_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            illegal_q   <= 1'b0;
            flags_q     <= 4'b0000;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            prod_q      <= '0;
            mul_s_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (out_valid_q && Out_Ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (accept && is_mul) begin
                        state_q <= StMulBusy;
                        mul_a_q <= A;
                        mul_b_q <= B;
                        prod_q  <= (OP == OP_MLA) ? Acc : '0;
                        mul_s_q <= S;
                        cnt_q   <= '0;
                    end else if (accept && OP[4]) begin
                        out_q       <= '0;
                        wr_en_q     <= 1'b0;
                        illegal_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else if (accept) begin
                        out_q       <= dp_result;
                        wr_en_q     <= !is_compare(OP);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        if (S || is_compare(OP)) begin
                            flags_q[FLAG_N] <= dp_result[WIDTH-1];
                            flags_q[FLAG_Z] <= (dp_result == '0);
                            if (!is_logical(OP)) begin
                                flags_q[FLAG_C] <= dp_c;
                                flags_q[FLAG_V] <= dp_v;
                            end
                        end
                    end else if (Flags_Load) begin
                        flags_q <= Flags_In;
                    end
                end
                StMulBusy: begin
                    prod_q  <= prod_next;
                    mul_a_q <= mul_a_q << 1;
                    mul_b_q <= mul_b_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MUL_STEPS - 1)) begin
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        out_q       <= prod_next;
                        wr_en_q     <= 1'b1;
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        if (mul_s_q) begin
                            flags_q[FLAG_N] <= prod_next[WIDTH-1];
                            flags_q[FLAG_Z] <= (prod_next == '0);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Bench for arm_alu_seq: vector table, hand-written multi-cycle sequences and randomized ops
// against an arithmetic reference model.
module tb_arm_alu_seq;
    import arm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, s, flags_load, out_valid, out_ready, wr_en, illegal;
    logic [31:0] a, b, acc, out;
    logic [4:0]  op;
    logic [3:0]  flags_in, flags_out;

    logic        in_valid8, in_ready8, s8, flags_load8, out_valid8, out_ready8, wr_en8, illegal8;
    logic [7:0]  a8, b8, acc8, out8;
    logic [4:0]  op8;
    logic [3:0]  flags_in8, flags_out8;

    int errors = 0;
    int checks = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    arm_alu_seq #(.WIDTH(32)) dut (
        .Clk(clk), .Reset_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready), .A(a), .B(b),
        .Acc(acc), .OP(op), .S(s), .Flags_Load(flags_load), .Flags_In(flags_in),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Out(out), .Wr_En(wr_en),
        .Illegal(illegal), .FLAGS_OUT(flags_out)
    );

    arm_alu_seq #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset_n(rst_n), .In_Valid(in_valid8), .In_Ready(in_ready8), .A(a8), .B(b8),
        .Acc(acc8), .OP(op8), .S(s8), .Flags_Load(flags_load8), .Flags_In(flags_in8),
        .Out_Valid(out_valid8), .Out_Ready(out_ready8), .Out(out8), .Wr_En(wr_en8),
        .Illegal(illegal8), .FLAGS_OUT(flags_out8)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_flags(input logic [3:0] f);
        flags_load = 1'b1;
        flags_in   = f;
        @(posedge clk);
        @(negedge clk);
        flags_load = 1'b0;
    endtask

    // Called at a negedge with the block idle; returns the number of edges until Out_Valid.
    task automatic issue32(input logic [4:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                           input logic [31:0] acc_v, input logic s_v, output int lat);
        in_valid = 1'b1;
        op = op_v; a = a_v; b = b_v; acc = acc_v; s = s_v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic void add_model(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                      output logic [31:0] r, output logic c, output logic v);
        longint u, sr;
        u  = longint'(x) + longint'(y) + longint'(ci);
        sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        r  = u[31:0];
        c  = (u > 64'sd4294967295);
        v  = (sr > SMAX) || (sr < SMIN);
    endfunction

    function automatic void sub_model(input logic [31:0] m, input logic [31:0] n, input logic bi,
                                      output logic [31:0] r, output logic c, output logic v);
        longint d, sd;
        d  = longint'(m) - longint'(n) - longint'(bi);
        sd = longint'($signed(m)) - longint'($signed(n)) - longint'(bi);
        r  = d[31:0];
        c  = (d >= 0);
        v  = (sd > SMAX) || (sd < SMIN);
    endfunction

    function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] ac, input logic sv, input logic [3:0] fi,
                                  output logic [31:0] r, output logic wr, output logic ill,
                                  output logic [3:0] fo);
        logic c, v, arith, upd;
        logic [63:0] p;
        c = fi[1]; v = fi[0]; arith = 1'b0; upd = sv; wr = 1'b1; ill = 1'b0; r = '0;
        case (o)
            5'd0, 5'd8:  r = x & y;
            5'd1, 5'd9:  r = x ^ y;
            5'd2, 5'd10: begin sub_model(x, y, 1'b0, r, c, v); arith = 1'b1; end
            5'd3:        begin sub_model(y, x, 1'b0, r, c, v); arith = 1'b1; end
            5'd4, 5'd11: begin add_model(x, y, 1'b0, r, c, v); arith = 1'b1; end
            5'd5:        begin add_model(x, y, fi[1], r, c, v); arith = 1'b1; end
            5'd6:        begin sub_model(x, y, !fi[1], r, c, v); arith = 1'b1; end
            5'd7:        begin sub_model(y, x, !fi[1], r, c, v); arith = 1'b1; end
            5'd12:       r = x | y;
            5'd13:       r = y;
            5'd14:       r = x & ~y;
            5'd15:       r = ~y;
            5'd16, 5'd17: begin
                p = 64'(x) * 64'(y) + ((o == 5'd17) ? 64'(ac) : 64'd0);
                r = p[31:0];
            end
            default: begin ill = 1'b1; wr = 1'b0; upd = 1'b0; end
        endcase
        if (o >= 5'd8 && o <= 5'd11) begin
            wr  = 1'b0;
            upd = 1'b1;
        end
        fo = fi;
        if (upd) fo = {r[31], r == 32'd0, arith ? c : fi[1], arith ? v : fi[0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  pre;
        logic [31:0] exp_out;
        logic        exp_wr;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int          lat, n, bad;
        logic [31:0] r_m;
        logic        wr_m, ill_m;
        logic [3:0]  f_m, model_flags;
        logic [4:0]  rop;
        logic [31:0] ra, rb, racc;
        logic        rs;

        vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h1,        1'b1, 4'b0000, 32'h0,        1'b1, 4'b0110};
        vecs[1]  = '{OP_SUB, 32'h5,        32'h7,        1'b1, 4'b0000, 32'hFFFFFFFE, 1'b1, 4'b1000};
        vecs[2]  = '{OP_RSB, 32'h3,        32'hA,        1'b1, 4'b0000, 32'h7,        1'b1, 4'b0010};
        vecs[3]  = '{OP_ADC, 32'h1,        32'h1,        1'b1, 4'b0010, 32'h3,        1'b1, 4'b0000};
        vecs[4]  = '{OP_SBC, 32'h5,        32'h3,        1'b1, 4'b0000, 32'h1,        1'b1, 4'b0010};
        vecs[5]  = '{OP_RSC, 32'h3,        32'h5,        1'b1, 4'b0010, 32'h2,        1'b1, 4'b0010};
        vecs[6]  = '{OP_EOR, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b1, 4'b0011, 32'h0,        1'b1, 4'b0111};
        vecs[7]  = '{OP_BIC, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 4'b1010, 32'hFFFF0000, 1'b1, 4'b1010};
        vecs[8]  = '{OP_MVN, 32'h0,        32'h0,        1'b1, 4'b0001, 32'hFFFFFFFF, 1'b1, 4'b1001};
        vecs[9]  = '{OP_TEQ, 32'h5,        32'h5,        1'b0, 4'b0000, 32'h0,        1'b0, 4'b0100};
        vecs[10] = '{OP_CMN, 32'h80000000, 32'h80000000, 1'b0, 4'b0000, 32'h0,        1'b0, 4'b0111};
        vecs[11] = '{OP_MOV, 32'h0,        32'h12345678, 1'b1, 4'b0110, 32'h12345678, 1'b1, 4'b0010};
        vecs[12] = '{OP_ORR, 32'h1,        32'h2,        1'b0, 4'b1111, 32'h3,        1'b1, 4'b1111};
        vecs[13] = '{OP_AND, 32'h80000000, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h80000000, 1'b1, 4'b1000};
        vecs[14] = '{OP_TST, 32'h1,        32'h2,        1'b0, 4'b0000, 32'h0,        1'b0, 4'b0100};
        vecs[15] = '{OP_CMP, 32'h7,        32'h5,        1'b0, 4'b1001, 32'h0,        1'b0, 4'b0010};
        vecs[16] = '{OP_SBC, 32'h80000000, 32'h0,        1'b1, 4'b0000, 32'h7FFFFFFF, 1'b1, 4'b0011};
        vecs[17] = '{OP_ADC, 32'h7FFFFFFF, 32'h0,        1'b1, 4'b0010, 32'h80000000, 1'b1, 4'b1001};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; s = 1'b0; flags_load = 1'b0; flags_in = 4'b0;
        a = '0; b = '0; acc = '0; op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; s8 = 1'b0; flags_load8 = 1'b0; flags_in8 = 4'b0;
        a8 = '0; b8 = '0; acc8 = '0; op8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out", out, 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst flags", 32'(flags_out), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst8 flags", 32'(flags_out8), 32'd0);
        check("rst8 out_valid", 32'(out_valid8), 32'd0);

        // ADD wrapping to zero
        issue32(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, lat);
        check("add latency", 32'(lat), 32'd1);
        check("add out", out, 32'h0);
        check("add wr_en", 32'(wr_en), 32'd1);
        check("add flags", 32'(flags_out), 32'b0110);

        // CMP then ADC back-to-back: ADC must see C cleared by CMP
        in_valid = 1'b1; op = OP_CMP; a = 32'd5; b = 32'd7; s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cmp wr_en", 32'(wr_en), 32'd0);
        check("cmp flags", 32'(flags_out), 32'b1000);
        check("cmp in_ready", 32'(in_ready), 32'd1);
        op = OP_ADC; a = 32'd1; b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("adc out", out, 32'd2);
        check("adc wr_en", 32'(wr_en), 32'd1);
        check("adc flags", 32'(flags_out), 32'b1000);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            load_flags(vecs[i].pre);
            issue32(vecs[i].op, vecs[i].a, vecs[i].b, 32'h0, vecs[i].s, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
            if (vecs[i].exp_wr) check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d illegal", i), 32'(illegal), 32'd0);
            check($sformatf("vec%0d flags", i), 32'(flags_out), 32'(vecs[i].exp_flags));
        end

        // MLA: busy for WIDTH cycles, inputs and Flags_Load ignored meanwhile
        load_flags(4'b0011);
        in_valid = 1'b1; op = OP_MLA; a = 32'h10000; b = 32'h10001; acc = 32'd3; s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = OP_ADD; a = 32'd1; b = 32'd1; flags_load = 1'b1; flags_in = 4'b1111;
        n = 0;
        bad = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) bad++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        flags_load = 1'b0;
        check("mla edges after accept", 32'(n), 32'd32);
        check("mla in_ready low cycles", 32'(bad), 32'd0);
        check("mla out", out, 32'h00010003);
        check("mla wr_en", 32'(wr_en), 32'd1);
        check("mla flags", 32'(flags_out), 32'b0011);

        // Backpressure: result held while Out_Ready=0
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_ADD; a = 32'h7FFFFFFF; b = 32'h1; s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = OP_SUB; a = 32'd3; b = 32'd1; s = 1'b0;
        check("stall out", out, 32'h80000000);
        check("stall flags", 32'(flags_out), 32'b1001);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || in_ready || out !== 32'h80000000) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        check("stall hold violations", 32'(bad), 32'd0);
        out_ready = 1'b1;
        #1;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("replace out_valid", 32'(out_valid), 32'd1);
        check("replace out", out, 32'd2);
        check("replace flags", 32'(flags_out), 32'b1001);
        @(posedge clk);
        @(negedge clk);
        check("drain out_valid", 32'(out_valid), 32'd0);

        // Reserved opcode, then Flags_Load
        issue32(5'd20, 32'h1234, 32'h5678, 32'h0, 1'b1, lat);
        check("rsv out", out, 32'd0);
        check("rsv illegal", 32'(illegal), 32'd1);
        check("rsv wr_en", 32'(wr_en), 32'd0);
        check("rsv flags", 32'(flags_out), 32'b1001);
        load_flags(4'b0010);
        check("flags_load", 32'(flags_out), 32'b0010);
        flags_load = 1'b1; flags_in = 4'b1111;
        issue32(OP_MOV, 32'h0, 32'h5, 32'h0, 1'b0, lat);
        flags_load = 1'b0;
        check("flags_load during accept", 32'(flags_out), 32'b0010);
        check("mov out", out, 32'd5);

        // Randomized ops against the reference model
        load_flags(4'b0000);
        model_flags = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                f_m = 4'($urandom);
                load_flags(f_m);
                model_flags = f_m;
            end
            rop = 5'($urandom_range(0, 31));
            ra = pick(); rb = pick(); racc = pick(); rs = 1'($urandom);
            model(rop, ra, rb, racc, rs, model_flags, r_m, wr_m, ill_m, f_m);
            issue32(rop, ra, rb, racc, rs, lat);
            check($sformatf("rand%0d op%0d latency", i, rop), 32'(lat),
                  (rop == 5'd16 || rop == 5'd17) ? 32'd33 : 32'd1);
            if (wr_m || ill_m) check($sformatf("rand%0d op%0d out", i, rop), out, r_m);
            check($sformatf("rand%0d op%0d wr_en", i, rop), 32'(wr_en), 32'(wr_m));
            check($sformatf("rand%0d op%0d illegal", i, rop), 32'(illegal), 32'(ill_m));
            check($sformatf("rand%0d op%0d flags", i, rop), 32'(flags_out), 32'(f_m));
            model_flags = f_m;
        end

        // Reset in the middle of a MUL
        load_flags(4'b1111);
        in_valid = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd5; s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul rst out_valid", 32'(out_valid), 32'd0);
        check("midmul rst flags", 32'(flags_out), 32'd0);
        check("midmul rst out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst in_ready", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) bad++;
            @(negedge clk);
        end
        check("post rst stale result", 32'(bad), 32'd0);

        // WIDTH=8 instance
        in_valid8 = 1'b1; op8 = OP_SUB; a8 = 8'h80; b8 = 8'h01; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        check("w8 sub out_valid", 32'(out_valid8), 32'd1);
        check("w8 sub out", 32'(out8), 32'h7F);
        check("w8 sub flags", 32'(flags_out8), 32'b0011);
        in_valid8 = 1'b1; op8 = OP_MUL; a8 = 8'd13; b8 = 8'd11; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("w8 mul latency", 32'(n), 32'd9);
        check("w8 mul out", 32'(out8), 32'h8F);
        check("w8 mul flags", 32'(flags_out8), 32'b1011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_alu_seq.md
Name: arm_alu_seq

Overview:
Parametrised, sequential successor to the combinational ARM ALU. It executes the 16 ARM data-processing opcodes plus an iterative MUL/MLA. Operands and results move through valid/ready handshakes, and the NZCV flag register is held inside the block. It sits between the register-read stage and writeback in the CPU datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
MUL_STEPS, WIDTH, shift-add iterations for MUL/MLA (fixed = WIDTH; listed for bench reference)

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
In_Valid  in  1  operation presented
In_Ready  out  1  block accepts operation this cycle
A  in  WIDTH  operand Rn (multiplicand for MUL)
B  in  WIDTH  operand Op2 (multiplier for MUL)
Acc  in  WIDTH  accumulate operand for MLA
OP  in  5  opcode: 0-15 ARM DP order (AND,EOR,SUB,RSB,ADD,ADC,SBC,RSC,TST,TEQ,CMP,CMN,ORR,MOV,BIC,MVN), 16 MUL, 17 MLA, 18-31 reserved
S  in  1  update flags on completion
Flags_Load  in  1  overwrite flag register from Flags_In
Flags_In  in  4  NZCV value for Flags_Load
Out_Valid  out  1  result register holds a completed op
Out_Ready  in  1  consumer takes result
Out  out  WIDTH  result
Wr_En  out  1  result must be written back (0 for TST/TEQ/CMP/CMN/reserved)
Illegal  out  1  completed op was reserved opcode
FLAGS_OUT  out  4  current NZCV register {N,Z,C,V}

Behaviour:
- Reset (async assert, sync release): state IDLE; Out=0, Out_Valid=0, Wr_En=0, Illegal=0, FLAGS_OUT=0000, MUL counters cleared. Reset mid-MUL aborts the op; no result is produced.
- Handshake: In_Ready = (state==IDLE) && (!Out_Valid || Out_Ready). An op is accepted on the edge where In_Valid && In_Ready. Out/Wr_En/Illegal stay stable while Out_Valid && !Out_Ready. Out_Valid falls on the edge with Out_Ready=1 unless a new result lands on that same edge.
- FSM states: IDLE, MUL_BUSY.
  - IDLE: DP or reserved op accepted at edge k -> result registered at edge k, Out_Valid=1 from k, i.e. visible the cycle after acceptance (latency 1). Back-to-back throughput is 1 op/cycle when Out_Ready=1.
  - IDLE: MUL/MLA accepted -> MUL_BUSY. Latch A, B, Acc, S, op; product accumulator = (MLA ? Acc : 0); step counter = 0.
  - MUL_BUSY: each cycle, if B[cnt] is set add A<<cnt (mod 2^WIDTH); cnt++. When cnt reaches WIDTH-1, register the result, set Out_Valid, return to IDLE. Latency is WIDTH+1 edges from acceptance to Out_Valid (33 for WIDTH=32).
  - In MUL_BUSY, In_Ready=0 and inputs are ignored.
- Arithmetic, all mod 2^WIDTH:
  - SUB = A-B; RSB = B-A; ADC = A+B+C; SBC = A-B-!C; RSC = B-A-!C.
  - C for add-type ops = carry out. C for sub-type ops = NOT borrow.
  - V = signed overflow.
  - Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) and MUL/MLA: only N and Z update; C and V keep their values.
  - N = result[WIDTH-1]; Z = (result==0).
  - Compare ops (TST, TEQ, CMP, CMN): Wr_En=0; flags update regardless of S (ARM semantics).
  - Reserved opcodes: Out=0, Wr_En=0, Illegal=1, flags unchanged.
- Flag source: ADC/SBC/RSC read C from the register at acceptance. Flags are written at the completion edge, so an op accepted on the cycle after completion sees the new flags.
- Flags_Load: takes effect only when state==IDLE and no op is accepted that cycle. Otherwise it is ignored and not queued.

Decomposition:
- Package arm_alu_pkg:
  - opcode localparams (OP_AND..OP_MVN, OP_MUL=16, OP_MLA=17)
  - FSM state encoding
  - flag bit indices (N=3, Z=2, C=1, V=0)
  - function is_compare(op)
  - function is_logical(op)
- One sub-module: arm_alu_dp, the combinational WIDTH-parametrised DP core. Inputs: A, B, OP[3:0], Cin. Outputs: result, C, V. The top level owns the FSM, multiplier, flag register and handshake.

Test Plan:
1. Reset, then ADD A=0xFFFFFFFF B=1 S=1 -> next cycle Out=0, Out_Valid=1, Wr_En=1, FLAGS_OUT=0110 (Z, C).
2. CMP A=5 B=7 S=0, then ADC A=1 B=1 back-to-back with Out_Ready=1:
   - CMP -> Wr_En=0, FLAGS_OUT=1000 (N, borrow so C=0).
   - ADC -> Out=2, since C=0.
3. MLA A=0x10000 B=0x10001 Acc=3 S=1 -> In_Ready=0 for 32 cycles; Out_Valid on edge 33; Out=0x00010003; N=0, Z=0; C/V unchanged.
4. ADD A=0x7FFFFFFF B=1 S=1 with Out_Ready=0 for 5 cycles -> Out=0x80000000 held stable, FLAGS_OUT=1001, In_Ready=0 until Out_Ready=1.
5. OP=20 -> Out=0, Illegal=1, Wr_En=0, flags unchanged. Then Flags_Load with Flags_In=0010 while idle -> FLAGS_OUT=0010 next cycle.
6. Assert Reset_n=0 at MUL step 10 -> Out_Valid=0, FLAGS_OUT=0000 immediately. After release, In_Ready=1 and no stale result appears.
7. WIDTH=8 instance: SUB 0x80-0x01 S=1 -> Out=0x7F, FLAGS_OUT=0011 (C, V).
